// File: rtl/memory_be_port.sv
// memory_be_port: byte-enabled word memory with credit-limited, in-order, back-pressurable read responses.
// Define MEM_PARITY_EN to add per-byte even parity, the inj_parity_err port and a live rsp_err.
module memory_be_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
`ifdef MEM_PARITY_EN
  input  logic                    inj_parity_err,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr;
  logic                  unused_addr;
  logic                  acc, rd_acc, wr_acc, pop;
  logic [DATA_WIDTH-1:0] rd_data, push_data;
  logic                  rd_err, push, push_err;
  logic [DATA_WIDTH-1:0] fdata [DEPTH];
  logic                  ferr  [DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [CW-1:0]         fcnt, ocnt;
  assign addr        = req_addr[ADDR_WIDTH-1:0];
  assign unused_addr = ^req_addr[31:ADDR_WIDTH];
  assign req_ready   = !reset && (ocnt < CW'(DEPTH));
  assign acc         = req_valid && req_ready;
  assign rd_acc      = acc && !req_we;
  assign wr_acc      = acc && req_we;
  assign rd_data     = mem[addr];
  assign rsp_valid   = fcnt != '0;
  assign pop         = rsp_valid && rsp_ready;
  assign rsp_rdata   = rsp_valid ? fdata[rp] : '0;
  assign rsp_err     = rsp_valid && ferr[rp];
`ifdef MEM_PARITY_EN
  logic [NB-1:0] par [2**ADDR_WIDTH];
  logic [NB-1:0] calc;
  always_comb begin
    calc = '0;
    for (int i = 0; i < NB; i++) calc[i] = ^rd_data[8*i +: 8];
  end
  assign rd_err = |(calc ^ par[addr]);
  always_ff @(posedge clk)
    if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) par[addr][i] <= ^req_wdata[8*i +: 8] ^ inj_parity_err;
`else
  assign rd_err = 1'b0;
`endif
  // The array itself is never reset; only the response path is.
  always_ff @(posedge clk)
    if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[addr][8*i +: 8] <= req_wdata[8*i +: 8];
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign push      = rd_acc;
      assign push_data = rd_data;
      assign push_err  = rd_err;
    end else begin : g_stage
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          push      <= 1'b0;
          push_data <= '0;
          push_err  <= 1'b0;
        end else begin
          push      <= rd_acc;
          push_data <= rd_data;
          push_err  <= rd_err;
        end
    end
  endgenerate
  always_ff @(posedge clk)
    if (push) begin
      fdata[wp] <= push_data;
      ferr[wp]  <= push_err;
    end
  // ocnt counts reads in flight plus queued responses, so the FIFO cannot overflow.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
      ocnt <= '0;
    end else begin
      if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      if (pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      fcnt <= fcnt + CW'(push) - CW'(pop);
      ocnt <= ocnt + CW'(rd_acc) - CW'(pop);
    end
endmodule

// File: tb/tb_memory_be_port.sv
// tb_memory_be_port: scoreboard bench driving a READ_LATENCY=1 instance (ua) and a READ_LATENCY=2 instance (ub).
module tb_memory_be_port;
  logic clk = 0, reset = 1;
  logic a_valid = 0, a_we = 0, a_rsp_ready = 1;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic [3:0] a_be = 0;
  logic a_ready, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic b_valid = 0, b_we = 0, b_rsp_ready = 1;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic [3:0] b_be = 0;
  logic b_ready, b_rvalid, b_err;
  logic [31:0] b_rdata;
`ifdef MEM_PARITY_EN
  logic a_inj = 0, b_inj = 0;
`endif
  int checks = 0, errors = 0;
  logic [32:0] qa[$], qb[$];
  logic [31:0] ma[1024], mb[1024];
  logic [3:0] bad[1024];

  always #5 clk = ~clk;

  memory_be_port #(.READ_LATENCY(1)) ua (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
`ifdef MEM_PARITY_EN
    .inj_parity_err(a_inj),
`endif
    .rsp_valid(a_rvalid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err));

  memory_be_port #(.READ_LATENCY(2)) ub (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
`ifdef MEM_PARITY_EN
    .inj_parity_err(b_inj),
`endif
    .rsp_valid(b_rvalid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err));

  always @(negedge clk) begin : mon_a
    logic [32:0] e;
    if (a_rvalid && a_rsp_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_rsp_unexpected got=%h expected none", {a_err, a_rdata});
      end else begin
        e = qa.pop_front();
        if ({a_err, a_rdata} !== e) begin
          errors++;
          $display("FAIL a_rsp got=%h expected=%h", {a_err, a_rdata}, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [32:0] e;
    if (b_rvalid && b_rsp_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_rsp_unexpected got=%h expected none", {b_err, b_rdata});
      end else begin
        e = qb.pop_front();
        if ({b_err, b_rdata} !== e) begin
          errors++;
          $display("FAIL b_rsp got=%h expected=%h", {b_err, b_rdata}, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic inj);
    a_valid = 1; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
`ifdef MEM_PARITY_EN
    a_inj = inj;
`endif
    for (int n = 0; n < 40 && a_ready !== 1'b1; n++) tick();
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_req_timeout addr=%h ready=%b required 1", addr, a_ready);
    end
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) begin
          ma[addr[9:0]][8*i +: 8] = data[8*i +: 8];
          bad[addr[9:0]][i] = inj;
        end
    end else begin
`ifdef MEM_PARITY_EN
      qa.push_back({|bad[addr[9:0]], ma[addr[9:0]]});
`else
      qa.push_back({1'b0, ma[addr[9:0]]});
`endif
    end
    tick();
    a_valid = 0; a_we = 0;
`ifdef MEM_PARITY_EN
    a_inj = 0;
`endif
  endtask

  task automatic b_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    b_valid = 1; b_we = we; b_addr = addr; b_wdata = data; b_be = 4'hF;
    for (int n = 0; n < 40 && b_ready !== 1'b1; n++) tick();
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_req_timeout addr=%h ready=%b required 1", addr, b_ready);
    end
    if (we) mb[addr[9:0]] = data;
    else qb.push_back({1'b0, mb[addr[9:0]]});
    tick();
    b_valid = 0; b_we = 0;
  endtask

  task automatic drain_b;
    b_rsp_ready = 1;
    for (int n = 0; n < 40 && (qb.size() != 0 || b_rvalid); n++) tick();
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL b_drain_timeout pending=%0d required 0", qb.size());
    end
  endtask

  task automatic test_reset;
    checks += 2;
    if ({a_ready, a_rvalid, a_err, a_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_a outputs=%h required 0", {a_ready, a_rvalid, a_err, a_rdata});
    end
    if ({b_ready, b_rvalid, b_err, b_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_b outputs=%h required 0", {b_ready, b_rvalid, b_err, b_rdata});
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release ready=%b required 11", {a_ready, b_ready});
    end
  endtask

  task automatic test_latency;
    a_req(1, 5, 32'hDEADBEEF, 4'hF, 0);
    a_req(0, 5, 0, 0, 0);
    checks++;
    if ({a_rvalid, a_err, a_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL lat1 got v=%b e=%b d=%h required 1 0 deadbeef", a_rvalid, a_err, a_rdata);
    end
    tick();
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat1_single rvalid=%b required 0", a_rvalid);
    end
    b_req(1, 5, 32'hCAFEF00D);
    b_req(0, 5, 0);
    checks++;
    if (b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat2_early rvalid=%b required 0", b_rvalid);
    end
    tick();
    checks++;
    if ({b_rvalid, b_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL lat2 got v=%b d=%h required 1 cafef00d", b_rvalid, b_rdata);
    end
    tick();
  endtask

  task automatic test_byte_merge;
    a_req(1, 7, 32'h11223344, 4'hF, 0);
    a_req(1, 7, 32'hAABBCCDD, 4'b0101, 0);
    a_req(0, 7, 0, 0, 0);
    checks++;
    if (a_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_merge got=%h required 11bb33dd", a_rdata);
    end
    a_req(1, 7, 32'hFFFFFFFF, 4'b0000, 0);
    a_req(0, 7, 0, 0, 0);
    checks++;
    if (a_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_zero got=%h required 11bb33dd", a_rdata);
    end
    a_req(1, 32'h0000_0405, 32'h5A5A1234, 4'hF, 0);
    a_req(0, 5, 0, 0, 0);
    checks++;
    if (a_rdata !== 32'h5A5A1234) begin
      errors++;
      $display("FAIL alias got=%h required 5a5a1234", a_rdata);
    end
    tick();
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) b_req(1, i, 32'h10000000 + i);
    b_rsp_ready = 0;
    for (int i = 0; i < 3; i++) b_req(0, i, 0);
    b_valid = 1; b_we = 0; b_addr = 3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({b_ready, b_rvalid, b_rdata} !== {2'b01, 32'h10000000}) begin
        errors++;
        $display("FAIL bp_stall%0d got r=%b v=%b d=%h required 0 1 10000000", i, b_ready, b_rvalid, b_rdata);
      end
      tick();
    end
    b_rsp_ready = 1;
    qb.push_back({1'b0, mb[3]});
    checks++;
    if (b_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop_same_cycle ready=%b required 0", b_ready);
    end
    tick();
    checks++;
    if ({b_ready, b_rdata} !== {1'b1, 32'h10000001}) begin
      errors++;
      $display("FAIL bp_after_pop got r=%b d=%h required 1 10000001", b_ready, b_rdata);
    end
    tick();
    b_valid = 0;
    checks++;
    if (b_rdata !== 32'h10000002) begin
      errors++;
      $display("FAIL bp_rate got=%h required 10000002", b_rdata);
    end
    drain_b();
  endtask

  task automatic test_full_pop;
    for (int i = 10; i < 14; i++) b_req(1, i, 32'h20000000 + i);
    b_rsp_ready = 0;
    b_req(0, 10, 0);
    b_req(0, 11, 0);
    checks++;
    if (b_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_pre rvalid=%b required 1", b_rvalid);
    end
    b_rsp_ready = 1;
    b_req(0, 12, 0);
    b_rsp_ready = 0;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_count ready=%b required 1", b_ready);
    end
    b_req(0, 13, 0);
    checks++;
    if (b_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_full ready=%b required 0", b_ready);
    end
    drain_b();
  endtask

  task automatic test_reset_mid;
    b_req(1, 20, 32'h33445566);
    b_req(1, 21, 32'h778899AA);
    b_rsp_ready = 0;
    b_req(0, 20, 0);
    b_req(0, 21, 0);
    checks++;
    if (b_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre rvalid=%b required 1", b_rvalid);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({b_ready, b_rvalid, b_err, b_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs=%h required 0", {b_ready, b_rvalid, b_err, b_rdata});
    end
    qb.delete();
    @(posedge clk);
    #3 reset = 0;
    #1;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready ready=%b required 1", b_ready);
    end
    b_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale cycle=%0d rvalid=%b required 0", i, b_rvalid);
      end
    end
    b_req(0, 20, 0);
    b_req(0, 21, 0);
    drain_b();
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity;
    a_req(1, 9, 32'h0, 4'hF, 0);
    a_req(1, 9, 32'h000000FF, 4'b0001, 1);
    a_req(0, 9, 0, 0, 0);
    checks++;
    if ({a_err, a_rdata} !== {1'b1, 32'h000000FF}) begin
      errors++;
      $display("FAIL parity_inj got e=%b d=%h required 1 000000ff", a_err, a_rdata);
    end
    a_req(1, 9, 32'h000000FF, 4'b0001, 0);
    a_req(0, 9, 0, 0, 0);
    checks++;
    if ({a_err, a_rdata} !== {1'b0, 32'h000000FF}) begin
      errors++;
      $display("FAIL parity_clean got e=%b d=%h required 0 000000ff", a_err, a_rdata);
    end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) bad[i] = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_byte_merge();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    repeat (3) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL leftover qa=%0d qb=%0d required 0 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_be_port.md
Name: memory_be_port

Overview:
Parametrised, word-addressed synchronous data memory with a valid/ready request channel, per-byte write strobes and an in-order, back-pressurable read-response channel. It supersedes the fixed-width single-cycle memory. The core's load/store unit can stall on the response side without losing read data. It sits between the core's LSU or the quantum-control sequencer and on-chip SRAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from read accept to earliest rsp_valid; legal values 1 or 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  32  word address; only bits [ADDR_WIDTH-1:0] are used, upper bits ignored (aliasing).
req_wdata  in  DATA_WIDTH  write data.
req_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
rsp_valid  out  1  read data present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_WIDTH  read data; stable while rsp_valid && !rsp_ready.
rsp_err  out  1  parity error on this response; tied 0 without MEM_PARITY_EN.

Behaviour:
- Accept: request is accepted when req_valid && req_ready are high at the same rising edge.
- Write accept: each byte i with req_be[i]=1 is written on that edge; other bytes keep their contents. be=0 is a legal no-op. Writes produce no response.
- Read accept: the memory array is read on the accept edge. The response enters the read pipeline (READ_LATENCY-1 register stages) and then a response FIFO.
  - With no stall, rsp_valid rises exactly READ_LATENCY cycles after the accept edge.
- Ordering: responses are strictly in order. A read accepted in the cycle after a write to the same address returns the new data, including partially written bytes merged with old bytes.
- Credit: RSP_DEPTH = READ_LATENCY+1. outstanding = reads in pipeline + entries in FIFO.
  - req_ready = !reset && (outstanding < RSP_DEPTH). This is combinational from the counter and applies to both reads and writes.
  - The FIFO never overflows.
- Counter update per edge: +1 on read accept, −1 on rsp_valid && rsp_ready. A simultaneous accept and pop leaves it unchanged. When full, a pop in the same cycle does not make req_ready high in that cycle; ready rises the next cycle.
- Response channel: rsp_valid stays high until a pop. rsp_rdata and rsp_err must not change while stalled. Back-to-back pops at full rate are supported (one response per cycle).
- Reset (asynchronous, may occur mid-operation):
  - pipeline stages, FIFO pointers and counter clear immediately;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset is high;
  - in-flight reads are discarded;
  - the memory array is not cleared, and its contents are undefined after power-up.
- The first request can be accepted on the first rising edge after reset deasserts.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - one even-parity bit is stored per byte, updated with that byte's write;
  - adds input port inj_parity_err (1 bit). When it is high on a write accept, the stored parity of every written byte is inverted;
  - on read, parity is recomputed per byte; rsp_err = OR of mismatches and travels with its response;
  - reads of bytes never written may flag rsp_err.
- Undefined: no parity storage, no inj_parity_err port, rsp_err constant 0.

Test Plan:
- READ_LATENCY=1: write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 with rsp_ready=1 → rsp_valid one cycle after read accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte merge: write 0x11223344 with be=F, then 0xAABBCCDD with be=4'b0101 to addr 7; read → 0x11BB33DD.
- Backpressure, READ_LATENCY=2, rsp_ready=0: issue reads of addrs 0,1,2,3 → first three accepted on consecutive edges, then req_ready=0. rsp_valid stays high with addr 0 data stable. Raising rsp_ready → data for addrs 0,1,2 on consecutive cycles; addr 3 is accepted only after the first pop.
- Full with simultaneous pop and read: outstanding=RSP_DEPTH−1, read accept plus pop on the same edge → counter unchanged, no data lost, order preserved.
- Reset asserted mid-way through a 2-cycle read → rsp_valid falls immediately, no stale response after release, req_ready=1 on the first cycle after release. Memory written before reset still reads back correctly.
- MEM_PARITY_EN: write 0x000000FF to addr 9 with inj_parity_err=1, be=4'b0001, then read → rsp_err=1. Rewrite with inj_parity_err=0, then read → rsp_err=0, data 0x000000FF.
